// File: rtl/intm_rs_pkg.sv
// Shared widths, multiply/divide opcodes and the entry/issue payload types
// used by the integer multiply/divide reservation station.
package intm_rs_pkg;

    localparam int PRF_IDX_W  = 6;
    localparam int ROB_IDX_W  = 5;
    localparam int ARCH_IDX_W = 5;
    localparam int XLEN       = 32;

    typedef enum logic [2:0] {
        MD_MUL,
        MD_MULH,
        MD_MULHSU,
        MD_MULHU,
        MD_DIV,
        MD_DIVU,
        MD_REM,
        MD_REMU
    } md_op_e;

    typedef struct packed {
        md_op_e                  fu_opcode;
        logic [ROB_IDX_W-1:0]    rob_id;
        logic [ARCH_IDX_W-1:0]   rd_arch;
        logic [PRF_IDX_W-1:0]    rd_phy;
        logic [PRF_IDX_W-1:0]    rs1_phy;
        logic [PRF_IDX_W-1:0]    rs2_phy;
        logic                    rs1_ready;
        logic                    rs2_ready;
        logic [XLEN-1:0]         rs1_value;
        logic [XLEN-1:0]         rs2_value;
    } intm_rs_entry_t;

    typedef struct packed {
        md_op_e                  fu_opcode;
        logic [ROB_IDX_W-1:0]    rob_id;
        logic [ARCH_IDX_W-1:0]   rd_arch;
        logic [PRF_IDX_W-1:0]    rd_phy;
        logic [XLEN-1:0]         rs1_value;
        logic [XLEN-1:0]         rs2_value;
    } intm_rs_reg_t;

    // Strips the scheduling-only fields off an entry for the FU input register.
    function automatic intm_rs_reg_t to_issue(input intm_rs_entry_t e);
        intm_rs_reg_t r;
        r.fu_opcode = e.fu_opcode;
        r.rob_id    = e.rob_id;
        r.rd_arch   = e.rd_arch;
        r.rd_phy    = e.rd_phy;
        r.rs1_value = e.rs1_value;
        r.rs2_value = e.rs2_value;
        return r;
    endfunction

endpackage

// File: rtl/intm_rs_if.sv
// Dispatch, CDB snoop and FU issue signals of the reservation station.
// The slave modport is the station's view; master is the surrounding pipeline.
interface intm_rs_if #(
    parameter int CDB_WIDTH = 3
);
    import intm_rs_pkg::*;

    logic                                  dis_valid;
    logic                                  dis_ready;
    intm_rs_entry_t                        dis_uop;
    logic [CDB_WIDTH-1:0]                  cdb_valid;
    logic [CDB_WIDTH-1:0][PRF_IDX_W-1:0]   cdb_rd_phy;
    logic [CDB_WIDTH-1:0][XLEN-1:0]        cdb_rd_value;
    logic                                  nxt_valid;
    logic                                  nxt_ready;
    intm_rs_reg_t                          intm_rs_out;

    modport master (
        output dis_valid, dis_uop, cdb_valid, cdb_rd_phy, cdb_rd_value, nxt_ready,
        input  dis_ready, nxt_valid, intm_rs_out
    );

    modport slave (
        input  dis_valid, dis_uop, cdb_valid, cdb_rd_phy, cdb_rd_value, nxt_ready,
        output dis_ready, nxt_valid, intm_rs_out
    );

endinterface

// File: rtl/intm_rs_wakeup.sv
// Single-source CDB wakeup: a not-yet-ready source captures the value of the
// lowest-numbered CDB port broadcasting its physical register.
module intm_rs_wakeup
    import intm_rs_pkg::*;
#(
    parameter int CDB_WIDTH = 3
) (
    input  logic [PRF_IDX_W-1:0]                 phy,
    input  logic                                 ready,
    input  logic [XLEN-1:0]                      value,
    input  logic [CDB_WIDTH-1:0]                 cdb_valid,
    input  logic [CDB_WIDTH-1:0][PRF_IDX_W-1:0]  cdb_rd_phy,
    input  logic [CDB_WIDTH-1:0][XLEN-1:0]       cdb_rd_value,
    output logic                                 ready_next,
    output logic [XLEN-1:0]                      value_next
);

    // Scanning from the top port down lets the lowest matching port win.
    always_comb begin
        ready_next = ready;
        value_next = value;
        if (!ready) begin
            for (int p = CDB_WIDTH - 1; p >= 0; p--) begin
                if (cdb_valid[p] && (cdb_rd_phy[p] == phy)) begin
                    ready_next = 1'b1;
                    value_next = cdb_rd_value[p];
                end
            end
        end
    end

endmodule

// File: rtl/intm_rs.sv
// Integer multiply/divide reservation station: collapsing queue, oldest-ready
// issue. Define INTM_RS_PERF_EN to add the saturating perf counter outputs.
module intm_rs
    import intm_rs_pkg::*;
#(
    parameter int DEPTH     = 4,
    parameter int CDB_WIDTH = 3
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            flush,
    intm_rs_if.slave        bus
`ifdef INTM_RS_PERF_EN
    ,
    output logic [31:0]     perf_full_cycles,
    output logic [31:0]     perf_issue_stall
`endif
);

    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam int IDX_W = $clog2(DEPTH);

    intm_rs_entry_t         ent     [DEPTH];
    intm_rs_entry_t         nxt_ent [DEPTH];
    intm_rs_entry_t         src_in  [DEPTH+1];
    intm_rs_entry_t         woken   [DEPTH+1];
    logic [DEPTH:0]         w1_rdy;
    logic [DEPTH:0]         w2_rdy;
    logic [XLEN-1:0]        w1_val  [DEPTH+1];
    logic [XLEN-1:0]        w2_val  [DEPTH+1];
    logic [CNT_W-1:0]       count;
    logic [CNT_W-1:0]       wr_idx;
    logic [IDX_W-1:0]       sel;
    logic                   sel_found;
    logic                   do_dis;
    logic                   do_issue;

    // Slot DEPTH carries the incoming uop so a same-cycle broadcast is caught.
    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            src_in[i] = ent[i];
        end
        src_in[DEPTH] = bus.dis_uop;
        if (bus.dis_uop.rs1_phy == '0) begin
            src_in[DEPTH].rs1_ready = 1'b1;
            src_in[DEPTH].rs1_value = '0;
        end
        if (bus.dis_uop.rs2_phy == '0) begin
            src_in[DEPTH].rs2_ready = 1'b1;
            src_in[DEPTH].rs2_value = '0;
        end
    end

    for (genvar g = 0; g <= DEPTH; g++) begin : g_wake
        intm_rs_wakeup #(.CDB_WIDTH(CDB_WIDTH)) u_rs1 (
            .phy          (src_in[g].rs1_phy),
            .ready        (src_in[g].rs1_ready),
            .value        (src_in[g].rs1_value),
            .cdb_valid    (bus.cdb_valid),
            .cdb_rd_phy   (bus.cdb_rd_phy),
            .cdb_rd_value (bus.cdb_rd_value),
            .ready_next   (w1_rdy[g]),
            .value_next   (w1_val[g])
        );
        intm_rs_wakeup #(.CDB_WIDTH(CDB_WIDTH)) u_rs2 (
            .phy          (src_in[g].rs2_phy),
            .ready        (src_in[g].rs2_ready),
            .value        (src_in[g].rs2_value),
            .cdb_valid    (bus.cdb_valid),
            .cdb_rd_phy   (bus.cdb_rd_phy),
            .cdb_rd_value (bus.cdb_rd_value),
            .ready_next   (w2_rdy[g]),
            .value_next   (w2_val[g])
        );
    end

    always_comb begin
        for (int i = 0; i <= DEPTH; i++) begin
            woken[i]           = src_in[i];
            woken[i].rs1_ready = w1_rdy[i];
            woken[i].rs1_value = w1_val[i];
            woken[i].rs2_ready = w2_rdy[i];
            woken[i].rs2_value = w2_val[i];
        end
    end

    // Select looks only at registered readiness, so wakeup-to-issue is one cycle.
    always_comb begin
        sel       = '0;
        sel_found = 1'b0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if ((CNT_W'(i) < count) && ent[i].rs1_ready && ent[i].rs2_ready) begin
                sel       = IDX_W'(i);
                sel_found = 1'b1;
            end
        end
    end

    assign bus.dis_ready   = (count < CNT_W'(DEPTH));
    assign bus.nxt_valid   = sel_found;
    assign bus.intm_rs_out = sel_found ? to_issue(ent[sel]) : '0;

    assign do_dis   = bus.dis_valid && bus.dis_ready;
    assign do_issue = sel_found && bus.nxt_ready;
    assign wr_idx   = count - CNT_W'(do_issue);

    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            if (do_dis && (CNT_W'(i) == wr_idx)) begin
                nxt_ent[i] = woken[DEPTH];
            end else if (do_issue && (IDX_W'(i) >= sel) && (i < DEPTH - 1)) begin
                nxt_ent[i] = woken[i+1];
            end else begin
                nxt_ent[i] = woken[i];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            count <= '0;
        end else begin
            count <= count + CNT_W'(do_dis) - CNT_W'(do_issue);
            for (int i = 0; i < DEPTH; i++) begin
                ent[i] <= nxt_ent[i];
            end
        end
    end

`ifdef INTM_RS_PERF_EN
    // Both counters survive flush and stick at all-ones.
    always_ff @(posedge clk) begin
        if (rst) begin
            perf_full_cycles <= '0;
            perf_issue_stall <= '0;
        end else begin
            if ((count == CNT_W'(DEPTH)) && bus.dis_valid && (perf_full_cycles != '1)) begin
                perf_full_cycles <= perf_full_cycles + 32'd1;
            end
            if (sel_found && !bus.nxt_ready && (perf_issue_stall != '1)) begin
                perf_issue_stall <= perf_issue_stall + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_intm_rs.sv
// Directed self-checking bench for intm_rs: dispatch, wakeup, race, ordering,
// backpressure and flush scenarios with hand-computed expected outputs.
module tb_intm_rs;
    import intm_rs_pkg::*;

    logic clk;
    logic rst;
    logic flush;
    int   vectors;
    int   miscompares;

    intm_rs_if #(.CDB_WIDTH(3)) bus ();

`ifdef INTM_RS_PERF_EN
    logic [31:0] perf_full_cycles;
    logic [31:0] perf_issue_stall;
`endif

    intm_rs #(.DEPTH(4), .CDB_WIDTH(3)) dut (
        .clk   (clk),
        .rst   (rst),
        .flush (flush),
        .bus   (bus)
`ifdef INTM_RS_PERF_EN
        ,
        .perf_full_cycles (perf_full_cycles),
        .perf_issue_stall (perf_issue_stall)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic intm_rs_entry_t mk(input md_op_e op, input int rob, input int rd,
                                          input int p1, input bit r1, input int v1,
                                          input int p2, input bit r2, input int v2);
        intm_rs_entry_t e;
        e.fu_opcode = op;
        e.rob_id    = ROB_IDX_W'(rob);
        e.rd_arch   = ARCH_IDX_W'(rd);
        e.rd_phy    = PRF_IDX_W'(rd + 40);
        e.rs1_phy   = PRF_IDX_W'(p1);
        e.rs1_ready = r1;
        e.rs1_value = XLEN'(v1);
        e.rs2_phy   = PRF_IDX_W'(p2);
        e.rs2_ready = r2;
        e.rs2_value = XLEN'(v2);
        return e;
    endfunction

    function automatic intm_rs_reg_t expo(input intm_rs_entry_t e, input int v1, input int v2);
        intm_rs_reg_t r;
        r.fu_opcode = e.fu_opcode;
        r.rob_id    = e.rob_id;
        r.rd_arch   = e.rd_arch;
        r.rd_phy    = e.rd_phy;
        r.rs1_value = XLEN'(v1);
        r.rs2_value = XLEN'(v2);
        return r;
    endfunction

    task automatic applyStimulus(input logic dv, input intm_rs_entry_t uop, input logic nr);
        bus.dis_valid = dv;
        bus.dis_uop   = uop;
        bus.nxt_ready = nr;
    endtask

    task automatic cdbPort(input int p, input int phy, input int val);
        bus.cdb_valid[p]    = 1'b1;
        bus.cdb_rd_phy[p]   = PRF_IDX_W'(phy);
        bus.cdb_rd_value[p] = XLEN'(val);
    endtask

    task automatic cdbClear();
        bus.cdb_valid    = '0;
        bus.cdb_rd_phy   = '0;
        bus.cdb_rd_value = '0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    intm_rs_entry_t uA, uB, uC, q1, q2, q3, q4, qE, qF, qG, qH, none;

    initial begin
        vectors     = 0;
        miscompares = 0;
        uA   = mk(MD_MUL,    1,  3,  7, 1, 3,       9, 1, 5);
        uB   = mk(MD_DIV,    2,  4,  0, 0, 'h55,   12, 0, 'h77);
        uC   = mk(MD_REM,    3,  5, 20, 0, 'h1,    21, 1, 7);
        q1   = mk(MD_MULH,   4,  6, 30, 0, 0,      50, 1, 'h11);
        q2   = mk(MD_MULHU,  5,  7, 31, 0, 0,      51, 1, 'h22);
        q3   = mk(MD_DIVU,   6,  8, 32, 0, 0,      52, 1, 'h33);
        q4   = mk(MD_REMU,   7,  9, 33, 0, 0,      53, 1, 'h44);
        qE   = mk(MD_MULHSU, 8, 10, 54, 1, 'h55,   55, 1, 'h66);
        qF   = mk(MD_MUL,    9, 11, 40, 0, 0,      56, 1, 'h77);
        qG   = mk(MD_DIV,   10, 12, 57, 1, 1,      58, 1, 2);
        qH   = mk(MD_REM,   11, 13, 59, 1, 'h123,   0, 0, 'h999);
        none = '0;

        rst   = 1'b1;
        flush = 1'b0;
        applyStimulus(1'b0, none, 1'b0);
        cdbClear();
        tick();
        tick();
        checkOutput("reset_dis_ready", 128'(bus.dis_ready), 128'(1));
        checkOutput("reset_nxt_valid", 128'(bus.nxt_valid), 128'(0));
        checkOutput("reset_out", 128'(bus.intm_rs_out), 128'(0));
        rst = 1'b0;

        // Ready dispatch issues the following cycle.
        applyStimulus(1'b1, uA, 1'b1);
        tick();
        applyStimulus(1'b0, none, 1'b1);
        checkOutput("ready_valid", 128'(bus.nxt_valid), 128'(1));
        checkOutput("ready_out", 128'(bus.intm_rs_out), 128'(expo(uA, 3, 5)));
        tick();
        checkOutput("ready_drained", 128'(bus.nxt_valid), 128'(0));
        checkOutput("ready_dis_ready", 128'(bus.dis_ready), 128'(1));

        // CDB wakeup two cycles after dispatch; phy 0 forced ready with value 0.
        applyStimulus(1'b1, uB, 1'b1);
        tick();
        applyStimulus(1'b0, none, 1'b1);
        checkOutput("wake_wait0", 128'(bus.nxt_valid), 128'(0));
        tick();
        checkOutput("wake_wait1", 128'(bus.nxt_valid), 128'(0));
        cdbPort(2, 12, 'h10);
        checkOutput("wake_same_cycle", 128'(bus.nxt_valid), 128'(0));
        tick();
        cdbClear();
        checkOutput("wake_valid", 128'(bus.nxt_valid), 128'(1));
        checkOutput("wake_out", 128'(bus.intm_rs_out), 128'(expo(uB, 0, 'h10)));
        tick();
        checkOutput("wake_drained", 128'(bus.nxt_valid), 128'(0));

        // Dispatch races a broadcast; port 1 beats port 2.
        applyStimulus(1'b1, uC, 1'b1);
        cdbPort(1, 20, 'hABCD);
        cdbPort(2, 20, 'h9999);
        tick();
        applyStimulus(1'b0, none, 1'b1);
        cdbClear();
        checkOutput("race_valid", 128'(bus.nxt_valid), 128'(1));
        checkOutput("race_out", 128'(bus.intm_rs_out), 128'(expo(uC, 'hABCD, 7)));
        tick();
        checkOutput("race_drained", 128'(bus.nxt_valid), 128'(0));

        // Fill four waiting entries.
        applyStimulus(1'b1, q1, 1'b0);
        tick();
        applyStimulus(1'b1, q2, 1'b0);
        tick();
        applyStimulus(1'b1, q3, 1'b0);
        tick();
        checkOutput("fill3_dis_ready", 128'(bus.dis_ready), 128'(1));
        applyStimulus(1'b1, q4, 1'b0);
        tick();
        applyStimulus(1'b0, none, 1'b0);
        checkOutput("full_dis_ready", 128'(bus.dis_ready), 128'(0));
        checkOutput("full_nxt_valid", 128'(bus.nxt_valid), 128'(0));

        // Wake D, then B; B is older so it wins once both are ready.
        cdbPort(0, 33, 'hDDDD);
        tick();
        cdbClear();
        cdbPort(1, 31, 'hBBBB);
        checkOutput("old_d_out", 128'(bus.intm_rs_out), 128'(expo(q4, 'hDDDD, 'h44)));
        tick();
        cdbClear();
        checkOutput("old_b_out", 128'(bus.intm_rs_out), 128'(expo(q2, 'hBBBB, 'h22)));

        // Issue B while C wakes as it shifts down.
        applyStimulus(1'b0, none, 1'b1);
        cdbPort(0, 32, 'hCCCC);
        tick();
        applyStimulus(1'b0, none, 1'b0);
        cdbClear();
        checkOutput("shift_c_out", 128'(bus.intm_rs_out), 128'(expo(q3, 'hCCCC, 'h33)));
        checkOutput("shift_dis_ready", 128'(bus.dis_ready), 128'(1));

        // Dispatch E while C issues: occupancy stays at three.
        applyStimulus(1'b1, qE, 1'b1);
        tick();
        applyStimulus(1'b0, none, 1'b0);
        checkOutput("dis_issue_out", 128'(bus.intm_rs_out), 128'(expo(q4, 'hDDDD, 'h44)));
        checkOutput("dis_issue_dis_ready", 128'(bus.dis_ready), 128'(1));
        applyStimulus(1'b1, qF, 1'b0);
        tick();
        applyStimulus(1'b0, none, 1'b0);
        checkOutput("refull_dis_ready", 128'(bus.dis_ready), 128'(0));

        // Backpressure: the offer of D holds steady.
        for (int k = 0; k < 5; k++) begin
            tick();
            checkOutput("bp_valid", 128'(bus.nxt_valid), 128'(1));
            checkOutput("bp_out", 128'(bus.intm_rs_out), 128'(expo(q4, 'hDDDD, 'h44)));
        end
        applyStimulus(1'b0, none, 1'b1);
        tick();
        applyStimulus(1'b0, none, 1'b0);
        checkOutput("bp_release_out", 128'(bus.intm_rs_out), 128'(expo(qE, 'h55, 'h66)));
        tick();
        checkOutput("bp_single_issue", 128'(bus.intm_rs_out), 128'(expo(qE, 'h55, 'h66)));
        checkOutput("bp_dis_ready", 128'(bus.dis_ready), 128'(1));

        // Flush beats the concurrent dispatch of G.
        flush = 1'b1;
        applyStimulus(1'b1, qG, 1'b0);
        tick();
        flush = 1'b0;
        applyStimulus(1'b0, none, 1'b1);
        checkOutput("flush_nxt_valid", 128'(bus.nxt_valid), 128'(0));
        checkOutput("flush_dis_ready", 128'(bus.dis_ready), 128'(1));
        checkOutput("flush_out", 128'(bus.intm_rs_out), 128'(0));
        cdbPort(0, 30, 'h3030);
        cdbPort(1, 40, 'h4040);
        tick();
        cdbClear();
        checkOutput("flush_no_ghost", 128'(bus.nxt_valid), 128'(0));

        // Queue is usable after flush.
        applyStimulus(1'b1, qH, 1'b1);
        tick();
        applyStimulus(1'b0, none, 1'b1);
        checkOutput("post_flush_out", 128'(bus.intm_rs_out), 128'(expo(qH, 'h123, 0)));
        tick();
        checkOutput("post_flush_drained", 128'(bus.nxt_valid), 128'(0));

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
